regfile_scoreboard: RTL and testbench

Register file plus write-back scoreboard for the 5-stage pipeline. Decode reads source operands here before they are captured into the decode/execute pipeline register. Write-back returns results here, at the far end of the `rd` path. A 2-bit per-register pending-write counter holds decode (`stall`) until every in-flight writer of a needed register has retired. The write-back port bypasses into the same-cycle read data.

---
 rtl/regfile_scoreboard_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 tb/tb_regfile_scoreboard.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode / write-back bundle for the register file scoreboard.
// The master side is the pipeline (decode plus write-back stage); the slave side is the register file.
interface regfile_scoreboard_if #(
  parameter int RFW = 5,
  parameter int DW  = 32
);
  logic [RFW-1:0] rs1_addr;
  logic [RFW-1:0] rs2_addr;
  logic           issue_valid;
  logic           issue_wen;
  logic [RFW-1:0] issue_rd;
  logic           wb_valid;
  logic [RFW-1:0] wb_rd;
  logic [DW-1:0]  wb_data;
  logic [DW-1:0]  r1;
  logic [DW-1:0]  r2;
  logic           stall;
  logic           wb_err;

  modport master (
    output rs1_addr, rs2_addr, issue_valid, issue_wen, issue_rd,
    output wb_valid, wb_rd, wb_data,
    input  r1, r2, stall, wb_err
  );

  modport slave (
    input  rs1_addr, rs2_addr, issue_valid, issue_wen, issue_rd,
    input  wb_valid, wb_rd, wb_data,
    output r1, r2, stall, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending-write counter.
// Decode stalls while a source has an outstanding writer. Write-back bypasses into same-cycle reads
// and can release a stall in the cycle it retires the last writer.
module regfile_scoreboard #(
  parameter int RFW = 5,
  parameter int DW  = 32
) (
  input logic                clk,
  input logic                rst,
  regfile_scoreboard_if.slave bus
);
  localparam int NREG = 1 << RFW;
  localparam logic [RFW-1:0] ADDR_ZERO = {RFW{1'b0}};

  logic [DW-1:0] regs_r [NREG];
  logic [1:0]    cnt_r  [NREG];
  logic          wb_err_r;

  logic          wb_hit_s;
  logic          busy1_s;
  logic          busy2_s;
  logic          full_s;
  logic          stall_s;
  logic          issue_inc_s;
  logic          same_rd_s;
  logic [DW-1:0] r1_s;
  logic [DW-1:0] r2_s;

  // A register is busy unless it has no writer or this cycle's write-back retires its only one.
  function automatic logic busy_f(input logic [1:0] cnt, input logic retiring);
    busy_f = (cnt != 2'd0) && !(retiring && (cnt == 2'd1));
  endfunction

  // Register 0 is hard-wired; otherwise the write-back port wins over the stored value.
  function automatic logic [DW-1:0] read_f(input logic [RFW-1:0] addr, input logic bypass,
                                           input logic [DW-1:0] wb_data, input logic [DW-1:0] stored);
    if (addr == ADDR_ZERO) begin
      read_f = {DW{1'b0}};
    end else if (bypass) begin
      read_f = wb_data;
    end else begin
      read_f = stored;
    end
  endfunction

  // Read mux, hazard detection and issue/retire decisions.
  always_comb begin
    wb_hit_s    = bus.wb_valid && (bus.wb_rd != ADDR_ZERO);
    r1_s        = read_f(bus.rs1_addr, bus.wb_valid && (bus.wb_rd == bus.rs1_addr),
                         bus.wb_data, regs_r[bus.rs1_addr]);
    r2_s        = read_f(bus.rs2_addr, bus.wb_valid && (bus.wb_rd == bus.rs2_addr),
                         bus.wb_data, regs_r[bus.rs2_addr]);
    busy1_s     = busy_f(cnt_r[bus.rs1_addr], bus.wb_valid && (bus.wb_rd == bus.rs1_addr));
    busy2_s     = busy_f(cnt_r[bus.rs2_addr], bus.wb_valid && (bus.wb_rd == bus.rs2_addr));
    // A saturated destination may still issue when a write-back frees a slot this cycle.
    full_s      = bus.issue_wen && (bus.issue_rd != ADDR_ZERO) && (cnt_r[bus.issue_rd] == 2'd3)
                  && !(bus.wb_valid && (bus.wb_rd == bus.issue_rd));
    stall_s     = bus.issue_valid && (busy1_s || busy2_s || full_s);
    issue_inc_s = bus.issue_valid && !stall_s && bus.issue_wen && (bus.issue_rd != ADDR_ZERO);
    same_rd_s   = issue_inc_s && wb_hit_s && (bus.issue_rd == bus.wb_rd);
  end

  assign bus.r1     = r1_s;
  assign bus.r2     = r2_s;
  assign bus.stall  = stall_s;
  assign bus.wb_err = wb_err_r;

  // Register storage: write-back data lands at the edge; register 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else if (wb_hit_s) begin
      regs_r[bus.wb_rd] <= bus.wb_data;
    end else begin
      regs_r[bus.wb_rd] <= regs_r[bus.wb_rd];
    end
  end

  // Pending-writer counters: issue increments, write-back decrements without underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_r[i] <= 2'd0;
      end
    end else if (!same_rd_s) begin
      // issue_rd and wb_rd differ here, so the two updates never collide.
      if (issue_inc_s) begin
        cnt_r[bus.issue_rd] <= cnt_r[bus.issue_rd] + 2'd1;
      end
      if (wb_hit_s && (cnt_r[bus.wb_rd] != 2'd0)) begin
        cnt_r[bus.wb_rd] <= cnt_r[bus.wb_rd] - 2'd1;
      end
    end
  end

  // Sticky flag for a write-back with no matching outstanding writer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_err_r <= 1'b0;
    end else if (wb_hit_s && (cnt_r[bus.wb_rd] == 2'd0)) begin
      wb_err_r <= 1'b1;
    end else begin
      wb_err_r <= wb_err_r;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, reset sequence,
// then randomized traffic against a behavioural scoreboard model.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  regfile_scoreboard_if #(.RFW(5), .DW(32)) bus ();

  regfile_scoreboard #(.RFW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iv;
    logic        iwen;
    logic [4:0]  ird;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  vec_t tbl [21];

  // Behavioural model state.
  int unsigned m_cnt [32];
  logic [31:0] m_mem [32];
  bit          m_err;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic iv,
                              input logic iwen, input logic [4:0] ird, input logic wbv,
                              input logic [4:0] wbrd, input logic [31:0] wbd,
                              input logic [31:0] e_r1, input logic [31:0] e_r2,
                              input logic e_stall, input logic e_err);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.iv = iv; v.iwen = iwen; v.ird = ird;
    v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
    v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_stall = e_stall; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.rs1_addr    = v.rs1;
    bus.rs2_addr    = v.rs2;
    bus.issue_valid = v.iv;
    bus.issue_wen   = v.iwen;
    bus.issue_rd    = v.ird;
    bus.wb_valid    = v.wbv;
    bus.wb_rd       = v.wbrd;
    bus.wb_data     = v.wbd;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      m_mem[i] = 32'h0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (bus.wb_valid && bus.wb_rd == a) return bus.wb_data;
    return m_mem[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    bit retire_last;
    retire_last = bus.wb_valid && (bus.wb_rd == a) && (m_cnt[a] == 1);
    return (m_cnt[a] != 0) && !retire_last;
  endfunction

  function automatic bit m_stall();
    bit full;
    full = bus.issue_wen && (bus.issue_rd != 5'd0) && (m_cnt[bus.issue_rd] == 3)
           && !(bus.wb_valid && bus.wb_rd == bus.issue_rd);
    return bus.issue_valid && (m_busy(bus.rs1_addr) || m_busy(bus.rs2_addr) || full);
  endfunction

  // Apply the rising-edge effects of the current inputs to the model.
  function automatic void m_edge();
    bit inc;
    bit wb;
    inc = bus.issue_valid && !m_stall() && bus.issue_wen && (bus.issue_rd != 5'd0);
    wb  = bus.wb_valid && (bus.wb_rd != 5'd0);
    if (wb) begin
      if (m_cnt[bus.wb_rd] == 0) m_err = 1'b1;
      m_mem[bus.wb_rd] = bus.wb_data;
    end
    if (!(inc && wb && bus.issue_rd == bus.wb_rd)) begin
      if (inc) m_cnt[bus.issue_rd] = m_cnt[bus.issue_rd] + 1;
      if (wb && m_cnt[bus.wb_rd] > 0) m_cnt[bus.wb_rd] = m_cnt[bus.wb_rd] - 1;
    end
  endfunction

  initial begin
    vec_t v;
    // rs1 rs2 iv iwen ird wbv wbrd wbd | r1 r2 stall err
    tbl[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[1]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[2]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[3]  = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tbl[4]  = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tbl[5]  = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tbl[6]  = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 32'h12345678, 32'h12345678, 32'h0, 1'b0, 1'b0);
    tbl[7]  = mk(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h12345678, 32'h0, 1'b0, 1'b0);
    tbl[8]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[9]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[10] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[11] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tbl[12] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[13] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tbl[14] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[15] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 32'hA5, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[16] = mk(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'hA5, 32'h0, 1'b1, 1'b0);
    tbl[17] = mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h77, 32'h77, 32'h0, 1'b0, 1'b0);
    tbl[18] = mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h77, 32'h0, 1'b0, 1'b1);
    tbl[19] = mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h77, 32'h0, 1'b0, 1'b1);
    tbl[20] = mk(5'd12, 5'd12, 1'b0, 1'b0, 5'd0, 1'b1, 5'd12, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1);

    v = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(v);
    #2;
    chk("reset_r1", bus.r1, 32'h0);
    chk("reset_err", {31'd0, bus.wb_err}, 32'h0);
    #10 rst = 1'b0;

    // Directed vector table: one vector per cycle, sampled mid-cycle.
    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      #4;
      chk($sformatf("vec%0d_r1", i), bus.r1, tbl[i].e_r1);
      chk($sformatf("vec%0d_r2", i), bus.r2, tbl[i].e_r2);
      chk($sformatf("vec%0d_stall", i), {31'd0, bus.stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("vec%0d_err", i), {31'd0, bus.wb_err}, {31'd0, tbl[i].e_err});
    end

    // Mid-cycle reset clears data, error flag and pending counts immediately.
    @(posedge clk);
    #1;
    drive(mk(5'd3, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    #2 rst = 1'b1;
    #1;
    chk("midrst_r1", bus.r1, 32'h0);
    chk("midrst_r2", bus.r2, 32'h0);
    chk("midrst_err", {31'd0, bus.wb_err}, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(mk(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    #4;
    chk("postrst_no_stall", {31'd0, bus.stall}, 32'h0);
    @(posedge clk);
    #1;
    drive(mk(5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0));
    #4;
    chk("postrst_wb_bypass", bus.r1, 32'h5);
    chk("postrst_err_pre", {31'd0, bus.wb_err}, 32'h0);
    @(posedge clk);
    #1;
    drive(mk(5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    #4;
    chk("postrst_err_set", {31'd0, bus.wb_err}, 32'h1);
    chk("postrst_stored", bus.r1, 32'h5);

    // Randomized traffic against the model, with periodic resets.
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1 rst = 1'b0;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) begin
        rst = 1'b1;
        #1 rst = 1'b0;
        m_reset();
      end
      bus.rs1_addr    = 5'($urandom_range(0, 7));
      bus.rs2_addr    = 5'($urandom_range(0, 7));
      bus.issue_valid = ($urandom_range(0, 99) < 50);
      bus.issue_wen   = ($urandom_range(0, 99) < 70);
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.wb_valid    = ($urandom_range(0, 99) < 40);
      bus.wb_rd       = 5'($urandom_range(0, 7));
      bus.wb_data     = $urandom;
      #4;
      chk($sformatf("rnd%0d_r1", c), bus.r1, m_read(bus.rs1_addr));
      chk($sformatf("rnd%0d_r2", c), bus.r2, m_read(bus.rs2_addr));
      chk($sformatf("rnd%0d_stall", c), {31'd0, bus.stall}, {31'd0, m_stall()});
      chk($sformatf("rnd%0d_err", c), {31'd0, bus.wb_err}, {31'd0, m_err});
      m_edge();
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
